// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes and debounces an active-low pushbutton, then
// produces press/release pulses and an auto-repeating step enable.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse
);
    localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic          sync1_q, sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    state_t        state_q, state_d;
    logic          press_d, release_d, rpt, step_d;
    logic          pressed_q, press_q, release_q, step_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end

    assign press_d   = stable_q & ~stable_d;
    assign release_d = ~stable_q & stable_d;

    // Gating on the next-cycle level lets a coincident release suppress a repeat.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        rpt     = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (press_d) state_d = DELAY;
            end
            DELAY: begin
                if (tmr_q == TW'(REPEAT_DELAY - 1)) begin
                    state_d = REPEAT;
                    tmr_d   = '0;
                    rpt     = 1'b1;
                end
            end
            REPEAT: begin
                if (tmr_q == TW'(REPEAT_PERIOD - 1)) begin
                    tmr_d = '0;
                    rpt   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
        if (stable_d) begin
            state_d = IDLE;
            tmr_d   = '0;
            rpt     = 1'b0;
        end
    end

    assign step_d = press_d | rpt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync_q    <= 1'b1;
            stable_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
            tmr_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            sync1_q   <= key_n;
            sync_q    <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            pressed_q <= ~stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign step_pulse    = step_q;
endmodule
